// File: rtl/regfile_rename_if.sv
// Bundle of every signal between the rename register file and its user,
// apart from clk/reset.
//
// Signal semantics:
// - rd_reg / rd_data / rd_tag: combinational read ports.
// - dc_*, wb_*, ck_save, br_ok, mispred are single-cycle qualifiers. There is
//   no ready side; the register file accepts every request on the rising
//   edge where it is high.
// - ck_save is dropped while ck_full is high.
// - br_ok and mispred are ignored when br_id names a slot that is not valid.
//
// Modports:
// - master: the pipeline that drives requests.
// - slave:  the register file.
interface regfile_rename_if #(
    parameter int XLEN  = 32,
    parameter int NREG  = 64,
    parameter int TAGW  = 6,
    parameter int NRP   = 2,
    parameter int NWP   = 2,
    parameter int NCKPT = 4
);
    localparam int RW = $clog2(NREG);
    localparam int CW = $clog2(NCKPT);

    logic [NRP-1:0][RW-1:0]   rd_reg;
    logic [NRP-1:0][XLEN:0]   rd_data;
    logic [NRP-1:0][TAGW-1:0] rd_tag;

    logic                     dc_we;
    logic [RW-1:0]            dc_rd;
    logic [TAGW-1:0]          dc_tag;

    logic [NWP-1:0]           wb_we;
    logic [NWP-1:0][RW-1:0]   wb_reg;
    logic [NWP-1:0][TAGW-1:0] wb_tag;
    logic [NWP-1:0][XLEN-1:0] wb_data;

    logic                     ck_save;
    logic [CW-1:0]            ck_id;
    logic                     ck_full;
    logic                     br_ok;
    logic                     mispred;
    logic [CW-1:0]            br_id;

    modport master (
        output rd_reg,
        input  rd_data, rd_tag,
        output dc_we, dc_rd, dc_tag,
        output wb_we, wb_reg, wb_tag, wb_data,
        output ck_save,
        input  ck_id, ck_full,
        output br_ok, mispred, br_id
    );

    modport slave (
        input  rd_reg,
        output rd_data, rd_tag,
        input  dc_we, dc_rd, dc_tag,
        input  wb_we, wb_reg, wb_tag, wb_data,
        input  ck_save,
        output ck_id, ck_full,
        input  br_ok, mispred, br_id
    );
endinterface

// File: rtl/regfile_rename.sv
// Architectural register file with rename state (busy bit and ROB tag per
// register) and a ring of branch checkpoints of the busy/tag state.
//
// Ports:
//   clk    - single clock
//   reset  - synchronous, active high; clears busy, tags, checkpoint valids
//            and the tail pointer. Register values are not reset.
//   bus    - regfile_rename_if.slave:
//            - read ports with writeback bypass
//            - dispatch rename
//            - writeback ports
//            - checkpoint save/release/restore
//
// Register 0 is hardwired to {0,0} with tag 0. Writes to register 0 are
// dropped.
//
// Checkpoint slots form a ring:
// - tail_q is the next slot to save into; that slot is ck_id.
// - The ring is full when the tail slot is still valid.
// - A mispredict on slot b restores slot b, then discards b and every younger
//   slot up to tail-1, wrapping.
// - A mispredict or br_ok naming an invalid slot is ignored. Dispatch,
//   save and br_ok in that same cycle then act normally.
// - With NCKPT=1 the ring would need CW=0. Keep NCKPT at 2 or more.
module regfile_rename #(
    parameter int XLEN  = 32,
    parameter int NREG  = 64,
    parameter int TAGW  = 6,
    parameter int NRP   = 2,
    parameter int NWP   = 2,
    parameter int NCKPT = 4
) (
    input  logic             clk,
    input  logic             reset,
    regfile_rename_if.slave  bus
);
    localparam int RW = $clog2(NREG);
    localparam int CW = $clog2(NCKPT);

    logic [NREG-1:0]                       busy_q, busy_d, busy_wb;
    logic [NREG-1:0][TAGW-1:0]             tag_q, tag_d;
    logic [XLEN-1:0]                       rf_q [NREG];
    logic [XLEN-1:0]                       rf_d [NREG];
    logic [NCKPT-1:0][NREG-1:0]            ck_busy_q, ck_busy_d, ck_busy_wb;
    logic [NCKPT-1:0][NREG-1:0][TAGW-1:0]  ck_tag_q, ck_tag_d;
    logic [NCKPT-1:0]                      ck_valid_q, ck_valid_d;
    logic [CW-1:0]                         tail_q, tail_d;

    logic        mispred_take;
    logic        save_take;
    logic        br_ok_take;
    logic [CW:0] kill_cnt;
    logic [RW-1:0] rr;

    assign bus.ck_id   = tail_q;
    assign bus.ck_full = ck_valid_q[tail_q];

    assign mispred_take = bus.mispred && ck_valid_q[bus.br_id];
    assign save_take    = bus.ck_save && !ck_valid_q[tail_q];
    assign br_ok_take   = bus.br_ok && ck_valid_q[bus.br_id];

    // Number of slots a mispredict discards: br_id .. tail-1, wrapping.
    // When the tail equals br_id, the ring is full, so every slot goes.
    always_comb begin
        kill_cnt = {1'b0, tail_q - bus.br_id};
        if (kill_cnt == '0) begin
            kill_cnt = (CW+1)'(NCKPT);
        end
    end

    // Writeback busy clears, both on the live state and on every valid
    // checkpoint. A checkpoint taken this cycle copies busy_wb, so the
    // snapshot already holds this cycle's clears.
    always_comb begin
        busy_wb    = busy_q;
        ck_busy_wb = ck_busy_q;
        for (int p = 0; p < NWP; p++) begin
            if (bus.wb_we[p] && bus.wb_reg[p] != '0) begin
                if (bus.wb_tag[p] == tag_q[bus.wb_reg[p]]) begin
                    busy_wb[bus.wb_reg[p]] = 1'b0;
                end
                for (int c = 0; c < NCKPT; c++) begin
                    if (ck_valid_q[c] && ck_tag_q[c][bus.wb_reg[p]] == bus.wb_tag[p]) begin
                        ck_busy_wb[c][bus.wb_reg[p]] = 1'b0;
                    end
                end
            end
        end
    end

    // Register values. Ports are applied in ascending order, so the highest
    // port index wins a same-register collision. A mispredict does not
    // block data writes.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            rf_d[r] = rf_q[r];
        end
        for (int p = 0; p < NWP; p++) begin
            if (bus.wb_we[p] && bus.wb_reg[p] != '0) begin
                rf_d[bus.wb_reg[p]] = bus.wb_data[p];
            end
        end
    end

    // Rename and checkpoint next state.
    always_comb begin
        busy_d     = busy_wb;
        tag_d      = tag_q;
        ck_busy_d  = ck_busy_wb;
        ck_tag_d   = ck_tag_q;
        ck_valid_d = ck_valid_q;
        tail_d     = tail_q;
        if (mispred_take) begin
            busy_d = ck_busy_wb[bus.br_id];
            tag_d  = ck_tag_q[bus.br_id];
            tail_d = bus.br_id;
            for (int i = 0; i < NCKPT; i++) begin
                if ((CW+1)'(i) < kill_cnt) begin
                    ck_valid_d[bus.br_id + CW'(i)] = 1'b0;
                end
            end
        end else begin
            // Dispatch wins over a writeback clear on the same register.
            if (bus.dc_we && bus.dc_rd != '0) begin
                busy_d[bus.dc_rd] = 1'b1;
                tag_d[bus.dc_rd]  = bus.dc_tag;
            end
            // The snapshot takes the pre-dispatch state.
            if (save_take) begin
                ck_busy_d[tail_q]  = busy_wb;
                ck_tag_d[tail_q]   = tag_q;
                ck_valid_d[tail_q] = 1'b1;
                tail_d             = tail_q + CW'(1);
            end
            // A save needs an invalid tail slot and br_ok needs a valid
            // slot, so the two never touch the same slot.
            if (br_ok_take) begin
                ck_valid_d[bus.br_id] = 1'b0;
            end
        end
    end

    // Read ports. A busy register whose producer writes back this cycle is
    // bypassed. The downward scan leaves the lowest matching port in place.
    always_comb begin
        rr          = '0;
        bus.rd_data = '0;
        bus.rd_tag  = '0;
        for (int rp = 0; rp < NRP; rp++) begin
            rr = bus.rd_reg[rp];
            if (rr != '0) begin
                bus.rd_data[rp] = {busy_q[rr], rf_q[rr]};
                bus.rd_tag[rp]  = tag_q[rr];
                if (busy_q[rr]) begin
                    for (int p = NWP - 1; p >= 0; p--) begin
                        if (bus.wb_we[p] && bus.wb_reg[p] == rr && bus.wb_tag[p] == tag_q[rr]) begin
                            bus.rd_data[rp] = {1'b0, bus.wb_data[p]};
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q     <= '0;
            tag_q      <= '0;
            ck_valid_q <= '0;
            tail_q     <= '0;
        end else begin
            busy_q     <= busy_d;
            tag_q      <= tag_d;
            ck_valid_q <= ck_valid_d;
            tail_q     <= tail_d;
        end
    end

    // Register values and checkpoint contents carry no reset. A checkpoint
    // is only read while its valid bit is set.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NREG; r++) begin
            rf_q[r] <= rf_d[r];
        end
        ck_busy_q <= ck_busy_d;
        ck_tag_q  <= ck_tag_d;
    end
endmodule

// File: tb/tb_regfile_rename.sv
module tb_regfile_rename;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    localparam logic [63:0] BUSY = 64'h1_0000_0000;

    regfile_rename_if bus ();

    regfile_rename dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    // Driver tasks.
    task automatic idle();
        bus.dc_we   = 1'b0;
        bus.dc_rd   = '0;
        bus.dc_tag  = '0;
        bus.wb_we   = '0;
        bus.wb_reg  = '0;
        bus.wb_tag  = '0;
        bus.wb_data = '0;
        bus.ck_save = 1'b0;
        bus.br_ok   = 1'b0;
        bus.mispred = 1'b0;
        bus.br_id   = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic dispatch(input int r, input int t);
        bus.dc_we  = 1'b1;
        bus.dc_rd  = 6'(r);
        bus.dc_tag = 6'(t);
    endtask

    task automatic wb(input int port, input int r, input int t, input logic [31:0] d);
        bus.wb_we[port]   = 1'b1;
        bus.wb_reg[port]  = 6'(r);
        bus.wb_tag[port]  = 6'(t);
        bus.wb_data[port] = d;
    endtask

    task automatic rd(input int port, input int r);
        bus.rd_reg[port] = 6'(r);
    endtask

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.rd_reg = '0;
        idle();

        // Reset.
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        rd(0, 5);
        #1;
        check("reset_ck_id", 64'(bus.ck_id), 64'd0);
        check("reset_ck_full", 64'(bus.ck_full), 64'd0);
        check("reset_r5_busy", 64'(bus.rd_data[0][32]), 64'd0);
        check("reset_r5_tag", 64'(bus.rd_tag[0]), 64'd0);

        // Dispatch, then writeback with same-cycle bypass.
        dispatch(5, 3);
        step();
        check("disp_r5_busy", 64'(bus.rd_data[0][32]), 64'd1);
        check("disp_r5_tag", 64'(bus.rd_tag[0]), 64'd3);
        wb(0, 5, 3, 32'hAA);
        #1;
        check("bypass_r5", 64'(bus.rd_data[0]), 64'hAA);
        step();
        check("wb_r5_data", 64'(bus.rd_data[0]), 64'hAA);
        check("wb_r5_tag", 64'(bus.rd_tag[0]), 64'd3);

        // Stale-tag writeback stores data but keeps busy.
        dispatch(5, 3);
        step();
        dispatch(5, 7);
        step();
        wb(1, 5, 3, 32'h55);
        #1;
        check("stale_no_bypass", 64'(bus.rd_data[0]), BUSY | 64'hAA);
        step();
        check("stale_r5_data", 64'(bus.rd_data[0]), BUSY | 64'h55);
        check("stale_r5_tag", 64'(bus.rd_tag[0]), 64'd7);

        // Dispatch overrides a same-cycle writeback clear.
        wb(0, 5, 7, 32'h77);
        dispatch(5, 8);
        step();
        check("dc_over_wb_data", 64'(bus.rd_data[0]), BUSY | 64'h77);
        check("dc_over_wb_tag", 64'(bus.rd_tag[0]), 64'd8);
        wb(0, 5, 8, 32'h78);
        step();
        check("r5_cleared", 64'(bus.rd_data[0]), 64'h78);

        // Two ports on one register: the higher port's data is stored,
        // and the lowest port wins the bypass.
        wb(0, 9, 0, 32'h11);
        wb(1, 9, 0, 32'h22);
        step();
        rd(1, 9);
        #1;
        check("wb_collide_store", 64'(bus.rd_data[1]), 64'h22);
        dispatch(9, 4);
        step();
        wb(0, 9, 4, 32'h33);
        wb(1, 9, 4, 32'h44);
        #1;
        check("bypass_low_port", 64'(bus.rd_data[1]), 64'h33);
        step();
        check("wb_collide_high", 64'(bus.rd_data[1]), 64'h44);

        // Checkpoint save and mispredict restore.
        rd(0, 4);
        dispatch(4, 1);
        step();
        bus.ck_save = 1'b1;
        step();
        check("save_ck_id", 64'(bus.ck_id), 64'd1);
        dispatch(4, 2);
        step();
        check("r4_tag2", 64'(bus.rd_tag[0]), 64'd2);
        bus.mispred = 1'b1;
        bus.br_id   = 2'd0;
        step();
        check("restore_r4_busy", 64'(bus.rd_data[0][32]), 64'd1);
        check("restore_r4_tag", 64'(bus.rd_tag[0]), 64'd1);
        check("restore_ck_id", 64'(bus.ck_id), 64'd0);
        check("restore_ck_full", 64'(bus.ck_full), 64'd0);

        // Writeback clears busy inside the checkpoint before the restore.
        bus.ck_save = 1'b1;
        step();
        dispatch(4, 2);
        step();
        wb(0, 4, 1, 32'h44);
        step();
        check("r4_busy_tag2", 64'(bus.rd_data[0]), BUSY | 64'h44);
        bus.mispred = 1'b1;
        bus.br_id   = 2'd0;
        step();
        check("restore_r4_free", 64'(bus.rd_data[0]), 64'h44);
        check("restore_r4_tag1", 64'(bus.rd_tag[0]), 64'd1);

        // Snapshot holds same-cycle writeback clears but not dispatch.
        rd(0, 6);
        rd(1, 7);
        dispatch(6, 10);
        step();
        bus.ck_save = 1'b1;
        wb(0, 6, 10, 32'h66);
        dispatch(7, 11);
        step();
        dispatch(6, 12);
        step();
        check("r6_tag12", 64'(bus.rd_tag[0]), 64'd12);
        check("r7_tag11", 64'(bus.rd_tag[1]), 64'd11);
        bus.mispred = 1'b1;
        bus.br_id   = 2'd0;
        step();
        check("snap_r6", 64'(bus.rd_data[0]), 64'h66);
        check("snap_r6_tag", 64'(bus.rd_tag[0]), 64'd10);
        check("snap_r7_busy", 64'(bus.rd_data[1][32]), 64'd0);
        check("snap_r7_tag", 64'(bus.rd_tag[1]), 64'd0);

        // Mispredict blocks dispatch and save; data still lands.
        bus.ck_save = 1'b1;
        step();
        rd(0, 8);
        bus.mispred = 1'b1;
        bus.br_id   = 2'd0;
        bus.ck_save = 1'b1;
        dispatch(8, 20);
        wb(0, 8, 0, 32'h88);
        step();
        check("prio_r8_data", 64'(bus.rd_data[0]), 64'h88);
        check("prio_r8_tag", 64'(bus.rd_tag[0]), 64'd0);
        check("prio_ck_id", 64'(bus.ck_id), 64'd0);
        check("prio_ck_full", 64'(bus.ck_full), 64'd0);

        // Fill the ring, release a slot, wrap.
        for (int i = 0; i < 4; i++) begin
            bus.ck_save = 1'b1;
            step();
        end
        check("full_after4", 64'(bus.ck_full), 64'd1);
        check("full_id", 64'(bus.ck_id), 64'd0);
        bus.ck_save = 1'b1;
        step();
        check("save5_ignored_id", 64'(bus.ck_id), 64'd0);
        check("save5_full", 64'(bus.ck_full), 64'd1);
        bus.br_ok = 1'b1;
        bus.br_id = 2'd0;
        step();
        check("brok_full", 64'(bus.ck_full), 64'd0);
        check("brok_id", 64'(bus.ck_id), 64'd0);
        bus.ck_save = 1'b1;
        step();
        check("wrap_id", 64'(bus.ck_id), 64'd1);
        check("wrap_full", 64'(bus.ck_full), 64'd1);
        bus.br_ok = 1'b1;
        bus.br_id = 2'd2;
        step();
        bus.br_ok = 1'b1;
        bus.br_id = 2'd2;
        step();
        check("brok_invalid_id", 64'(bus.ck_id), 64'd1);
        check("brok_invalid_full", 64'(bus.ck_full), 64'd1);
        bus.mispred = 1'b1;
        bus.br_id   = 2'd2;
        step();
        check("mis_invalid_id", 64'(bus.ck_id), 64'd1);
        bus.mispred = 1'b1;
        bus.br_id   = 2'd3;
        step();
        check("mis_wrap_id", 64'(bus.ck_id), 64'd3);
        check("mis_wrap_full", 64'(bus.ck_full), 64'd0);
        bus.ck_save = 1'b1;
        step();
        check("save3_id", 64'(bus.ck_id), 64'd0);
        check("save3_full", 64'(bus.ck_full), 64'd0);
        bus.ck_save = 1'b1;
        step();
        check("save0_id", 64'(bus.ck_id), 64'd1);
        check("save0_full", 64'(bus.ck_full), 64'd1);

        // Register 0 ignores dispatch and writeback.
        rd(0, 0);
        dispatch(0, 5);
        wb(1, 0, 0, 32'hFF);
        #1;
        check("r0_same_cycle", 64'(bus.rd_data[0]), 64'd0);
        step();
        check("r0_data", 64'(bus.rd_data[0]), 64'd0);
        check("r0_tag", 64'(bus.rd_tag[0]), 64'd0);

        // Reset overrides a valid mispredict and other traffic.
        rd(1, 4);
        bus.mispred = 1'b1;
        bus.br_id   = 2'd1;
        dispatch(0, 5);
        wb(0, 0, 0, 32'hFF);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("rst_r0_data", 64'(bus.rd_data[0]), 64'd0);
        check("rst_r0_tag", 64'(bus.rd_tag[0]), 64'd0);
        check("rst_ck_id", 64'(bus.ck_id), 64'd0);
        check("rst_ck_full", 64'(bus.ck_full), 64'd0);
        check("rst_r4_busy", 64'(bus.rd_data[1][32]), 64'd0);
        check("rst_r4_tag", 64'(bus.rd_tag[1]), 64'd0);

        // Final report.
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_rename.md
REGFILE_RENAME -- requirements
Module: regfile_rename

Interface
REQ-001 Parameter XLEN, default 32, SHALL be the data width of each architectural register.
REQ-002 Parameter NREG, default 64, SHALL be the register count, power of 2; RW = log2(NREG).
REQ-003 Parameter TAGW, default 6, SHALL be the ROB tag width.
REQ-004 Parameter NRP, default 2, SHALL be the number of read ports.
REQ-005 Parameter NWP, default 2, SHALL be the number of writeback ports.
REQ-006 Parameter NCKPT, default 4, SHALL be the number of checkpoints, power of 2; CW = log2(NCKPT).
REQ-007 Ports SHALL be as follows:
- clk  in  1  clock, single clock domain.
- reset  in  1  synchronous, active-high reset.
- rd_reg[NRP]  in  RW  read register index.
- rd_data[NRP]  out  XLEN+1  {busy, value}, combinational.
- rd_tag[NRP]  out  TAGW  current rename tag, combinational.
- dc_we  in  1  dispatch rename valid.
- dc_rd  in  RW  dispatch destination register.
- dc_tag  in  TAGW  ROB entry allocated to dc_rd.
- wb_we[NWP]  in  1  writeback valid.
- wb_reg[NWP]  in  RW  writeback register.
- wb_tag[NWP]  in  TAGW  writeback ROB tag.
- wb_data[NWP]  in  XLEN  writeback value.
- ck_save  in  1  take checkpoint.
- ck_id  out  CW  id the next save will use.
- ck_full  out  1  no free checkpoint.
- br_ok  in  1  branch resolved correct; release br_id.
- mispred  in  1  branch br_id mispredicted; restore.
- br_id  in  CW  checkpoint id for br_ok/mispred.

Function
REQ-008 Register 0 SHALL always read {0, 0} with tag 0; dispatch and writeback to register 0 SHALL be ignored.
REQ-009 A read of a register that is busy, where some wb port in the same cycle has wb_reg equal to it and wb_tag equal to its tag, SHALL return {0, wb_data} (bypass); if several ports match, the lowest port index wins.
REQ-010 Otherwise a read SHALL return {busy[r], rf[r]} and tag[r].
REQ-011 Each valid writeback SHALL update rf[wb_reg] at the clock edge regardless of tag.
REQ-012 A valid writeback SHALL clear busy[wb_reg] only when wb_tag equals tag[wb_reg].
REQ-013 When two wb ports write the same register in one cycle, the data of the higher port index SHALL be stored.
REQ-014 dc_we SHALL set busy[dc_rd]=1 and tag[dc_rd]=dc_tag; dispatch SHALL override a same-cycle writeback clear on that register.
REQ-015 ck_save with ck_full=0 SHALL store busy/tag into slot ck_id, set valid[ck_id], and advance the tail pointer by 1 mod NCKPT.
REQ-016 The stored busy/tag snapshot SHALL include same-cycle writeback clears and SHALL exclude same-cycle dispatch.
REQ-017 ck_save with ck_full=1 SHALL be ignored.
REQ-018 ck_id SHALL equal the tail pointer.
REQ-019 ck_full SHALL equal valid[tail].
REQ-020 Every valid writeback SHALL also clear busy in each valid checkpoint whose stored tag for wb_reg equals wb_tag.
REQ-021 br_ok SHALL clear valid[br_id]; the tail SHALL be unchanged.
REQ-022 mispred SHALL copy checkpoint br_id into busy/tag, with same-cycle writeback clears applied per REQ-020.
REQ-023 mispred SHALL set tail=br_id and clear valid for br_id and every slot from br_id up to tail-1, wrapping.
REQ-024 mispred SHALL take priority over dc_we, ck_save and br_ok in the same cycle, and those three SHALL be ignored; writeback data SHALL still be written.
REQ-025 mispred or br_ok on a slot that is not valid SHALL leave the state unchanged.
REQ-026 All updates SHALL take effect at the rising edge; state SHALL be visible on reads in the next cycle.

Reset
REQ-027 reset SHALL clear every busy bit and every tag, all checkpoint valid bits, and the tail pointer.
REQ-028 After reset, ck_id=0 and ck_full=0.
REQ-029 rf contents SHALL NOT be reset.
REQ-030 reset SHALL override all other inputs in the same cycle, including mispred mid-operation.

Verification
REQ-031 Dispatch r5 with tag 3, then writeback r5 with tag 3 and data 0xAA -> a same-cycle read gives {0,0xAA}; the next cycle reads {0,0xAA}.
REQ-032 Dispatch r5 tag 3, dispatch r5 tag 7, writeback r5 tag 3 -> r5 stays busy with tag 7, and rf[r5] holds the new data.
REQ-033 Dispatch r4 tag 1, ck_save (id 0), dispatch r4 tag 2, mispred id 0 -> r4 busy with tag 1, and ck_id returns to 0.
REQ-034 Same as the previous scenario, but writeback r4 tag 1 before the mispred -> after restore r4 is not busy.
REQ-035 Four saves -> ck_full=1 and a fifth save is ignored; br_ok id 0 followed by saves with wrap -> ck_full behaves per REQ-019.
REQ-036 Write to r0, dispatch r0, and reset asserted together with mispred -> r0 reads {0,0}; after reset everything is idle.
